// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared states and command-field constants for the SPI slave bridge
package spi_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMMAND,
        WRITE_DATA,
        READ_TURN,
        READ_DATA
    } frame_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACTIVE,
        BUS_GAP
    } bus_state_t;

    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_BITS     = 7;

    // Byte returned to the host when a read had to be abandoned or arrived late
    localparam logic [7:0] ABANDON_DATA = 8'hFF;

endpackage

// File: rtl/spi_slave_wishbone_bridge_edge_sync.sv
// rtl/spi_slave_wishbone_bridge_edge_sync.sv - synchronizers and edge detectors for sck, cs and mosi
module spiEdgeSync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic sck,
    input  logic cs,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_prev;
    logic                   cs_prev;

    // Synchronizer chains plus one history flop per edge-detected line; idle levels on reset
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_prev;
    assign sck_fall = ~sck_sync[SYNC_STAGES-1] & sck_prev;
    assign cs_fall  = ~cs_sync[SYNC_STAGES-1] & cs_prev;
    assign cs_rise  = cs_sync[SYNC_STAGES-1] & ~cs_prev;
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_wishbone_bridge.sv
// rtl/spi_slave_wishbone_bridge.sv - SPI mode-0 slave to 8-bit Wishbone master bridge (SPI_SLAVE_AUTOINC_EN enables burst address increment)
module spi_slave_wishbone_bridge
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_RETRIES = 3,
    parameter int WB_TIMEOUT  = 255
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] ADR_O,
    output logic [7:0] DAT_O,
    input  logic [7:0] DAT_I,
    output logic       WE_O,
    output logic       STB_O,
    output logic       CYC_O,
    input  logic       ACK_I,
    input  logic       RTY_I,
    output logic       overrun,
    output logic       busErr
);

`ifdef SPI_SLAVE_AUTOINC_EN
    localparam logic [ADDR_BITS-1:0] ADDR_STEP = 7'd1;
`else
    localparam logic [ADDR_BITS-1:0] ADDR_STEP = 7'd0;
`endif
    localparam int RETRY_W = $clog2(MAX_RETRIES + 2);
    localparam int TMO_W   = $clog2(WB_TIMEOUT + 2);

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

    frame_state_t         frame_q, frame_d;
    bus_state_t           bus_q, bus_d;
    logic [2:0]           bit_cnt;
    logic [7:0]           rx_shift, tx_shift, rx_next;
    logic [ADDR_BITS-1:0] addr_q, issue_addr;
    logic                 byte_done, issue_wr, issue_rd, load_tx;
    logic                 bus_start, bus_ack, bus_retry, bus_abandon;
    logic                 we_q, rd_ready;
    logic [7:0]           rd_data;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [TMO_W-1:0]     tmo_cnt;

    spiEdgeSync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .sck      (sck),
        .cs       (cs),
        .mosi     (mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .mosi_s   (mosi_s)
    );

    assign rx_next = {rx_shift[6:0], mosi_s};
    assign miso    = ~cs & tx_shift[7];

    // Frame FSM state register
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) frame_q <= IDLE;
        else        frame_q <= frame_d;
    end

    // Frame FSM next state and per-byte strobes; a closing cs edge is applied after the final sck edge
    always_comb begin
        frame_d    = frame_q;
        byte_done  = 1'b0;
        issue_wr   = 1'b0;
        issue_rd   = 1'b0;
        load_tx    = 1'b0;
        issue_addr = addr_q;
        if (frame_q != IDLE && sck_rise && bit_cnt == 3'd7) begin
            byte_done = 1'b1;
            case (frame_q)
                COMMAND: begin
                    issue_addr = rx_next[ADDR_BITS-1:0];
                    if (rx_next[CMD_WRITE_BIT]) begin
                        frame_d = WRITE_DATA;
                    end else begin
                        frame_d  = READ_TURN;
                        issue_rd = 1'b1;
                    end
                end
                WRITE_DATA: issue_wr = 1'b1;
                READ_TURN, READ_DATA: begin
                    frame_d    = READ_DATA;
                    load_tx    = 1'b1;
                    issue_rd   = 1'b1;
                    issue_addr = addr_q + ADDR_STEP;
                end
                default: ;
            endcase
        end
        if (cs_rise) frame_d = IDLE;
        if (cs_fall) frame_d = COMMAND;
    end

    // Serial shift registers, bit counter and frame address; a fresh byte is not shifted on its first fall
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            addr_q   <= '0;
        end else begin
            if (frame_q != IDLE) begin
                if (sck_rise) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    rx_shift <= rx_next;
                end
                if (sck_fall && bit_cnt != 3'd0) tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (byte_done) begin
                if (frame_q == COMMAND) addr_q <= rx_next[ADDR_BITS-1:0];
                else                    addr_q <= addr_q + ADDR_STEP;
            end
            if (load_tx) tx_shift <= rd_ready ? rd_data : ABANDON_DATA;
            if (cs_fall || cs_rise) begin
                bit_cnt  <= '0;
                tx_shift <= '0;
            end
        end
    end

    assign bus_start = (issue_wr | issue_rd) && bus_q == BUS_IDLE;

    // Bus FSM state register
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) bus_q <= BUS_IDLE;
        else        bus_q <= bus_d;
    end

    // Bus FSM next state: terminate on ACK, back off one cycle on RTY, give up on retries or timeout
    always_comb begin
        bus_d       = bus_q;
        bus_ack     = 1'b0;
        bus_retry   = 1'b0;
        bus_abandon = 1'b0;
        case (bus_q)
            BUS_IDLE: if (bus_start) bus_d = BUS_ACTIVE;
            BUS_ACTIVE: begin
                if (ACK_I) begin
                    bus_d   = BUS_IDLE;
                    bus_ack = 1'b1;
                end else if (RTY_I) begin
                    if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
                        bus_d       = BUS_IDLE;
                        bus_abandon = 1'b1;
                    end else begin
                        bus_d     = BUS_GAP;
                        bus_retry = 1'b1;
                    end
                end else if (tmo_cnt >= TMO_W'(WB_TIMEOUT)) begin
                    bus_d       = BUS_IDLE;
                    bus_abandon = 1'b1;
                end
            end
            BUS_GAP: bus_d = BUS_ACTIVE;
            default: bus_d = BUS_IDLE;
        endcase
    end

    assign STB_O = (bus_q == BUS_ACTIVE);
    assign CYC_O = STB_O;
    assign WE_O  = STB_O & we_q;

    // Bus address/data capture, retry and timeout counters, read-data handoff to the frame side
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            ADR_O     <= '0;
            DAT_O     <= '0;
            we_q      <= 1'b0;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            rd_data   <= '0;
            rd_ready  <= 1'b0;
        end else begin
            if (bus_start) begin
                ADR_O     <= {1'b0, issue_addr};
                we_q      <= issue_wr;
                retry_cnt <= '0;
                tmo_cnt   <= '0;
                if (issue_wr) DAT_O <= rx_next;
            end
            if (bus_q == BUS_ACTIVE) tmo_cnt <= tmo_cnt + 1'b1;
            if (bus_retry) begin
                retry_cnt <= retry_cnt + 1'b1;
                tmo_cnt   <= '0;
            end
            if (bus_ack && !we_q) begin
                rd_data  <= DAT_I;
                rd_ready <= 1'b1;
            end else if (bus_abandon && !we_q) begin
                rd_data  <= ABANDON_DATA;
                rd_ready <= 1'b1;
            end else if (load_tx || cs_fall) begin
                rd_ready <= 1'b0;
            end
        end
    end

    // Sticky error flags, cleared when the next frame opens
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            overrun <= 1'b0;
            busErr  <= 1'b0;
        end else begin
            if (cs_fall) begin
                overrun <= 1'b0;
                busErr  <= 1'b0;
            end
            if ((issue_wr && bus_q != BUS_IDLE) || (load_tx && !rd_ready)) overrun <= 1'b1;
            if (bus_abandon) busErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_slave_wishbone_bridge.sv
// tb/tb_spi_slave_wishbone_bridge.sv - directed bench for the SPI slave Wishbone bridge
module tb_spi_slave_wishbone_bridge;

    localparam int H = 6;
`ifdef SPI_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic       sck = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic       miso;
    logic [7:0] ADR_O, DAT_O;
    logic [7:0] DAT_I = 8'h00;
    logic       WE_O, STB_O, CYC_O;
    logic       ACK_I = 1'b0, RTY_I = 1'b0;
    logic       overrun, busErr;

    spi_slave_wishbone_bridge dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .WE_O(WE_O), .STB_O(STB_O),
        .CYC_O(CYC_O), .ACK_I(ACK_I), .RTY_I(RTY_I), .overrun(overrun), .busErr(busErr)
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
    } wb_rec_t;

    logic [7:0] mem [128];
    wb_rec_t    log_q [$];
    int         ack_delay = 0;
    int         rty_left = 0;
    int         wait_cnt = 0;
    int         stb_pulses = 0;
    int         stb_cycles = 0;
    bit         prev_stb = 1'b0;

    // Wishbone slave model: register bank with programmable wait states and retries
    always @(negedge CLK_I) begin
        ACK_I = 1'b0;
        RTY_I = 1'b0;
        if (STB_O && !prev_stb) stb_pulses++;
        prev_stb = STB_O;
        if (STB_O) begin
            stb_cycles++;
            if (wait_cnt >= ack_delay) begin
                wait_cnt = 0;
                if (rty_left > 0) begin
                    RTY_I = 1'b1;
                    rty_left--;
                end else begin
                    ACK_I = 1'b1;
                    if (WE_O) mem[ADR_O[6:0]] = DAT_O;
                    else      DAT_I = mem[ADR_O[6:0]];
                    log_q.push_back('{WE_O, ADR_O, DAT_O});
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    logic [7:0] tx_buf [4];
    logic [7:0] rx_buf [4];

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (H) @(posedge CLK_I);
            #2 sck = 1'b1;
            rx[i] = miso;
            repeat (H) @(posedge CLK_I);
            #2 sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(posedge CLK_I);
        #2 cs = 1'b0;
        repeat (H) @(posedge CLK_I);
    endtask

    task automatic cs_high();
        repeat (H) @(posedge CLK_I);
        #2 cs = 1'b1;
        repeat (5 * H) @(posedge CLK_I);
        #2;
    endtask

    task automatic run_frame(input int n);
        logic [7:0] r;
        cs_low();
        for (int k = 0; k < n; k++) begin
            spi_byte(tx_buf[k], r);
            rx_buf[k] = r;
        end
        cs_high();
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] adr0;
        logic [7:0] adr1_inc;
        logic [7:0] adr1_fix;
    } wr_vec_t;

    wr_vec_t vecs [4];

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int budget;

        vecs[0] = '{8'h85, 8'h3C, 8'hA5, 8'h05, 8'h06, 8'h05};
        vecs[1] = '{8'hFF, 8'h11, 8'h22, 8'h7F, 8'h00, 8'h7F};
        vecs[2] = '{8'h80, 8'h01, 8'hFE, 8'h00, 8'h01, 8'h00};
        vecs[3] = '{8'hC0, 8'h77, 8'h88, 8'h40, 8'h41, 8'h40};
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA0;

        repeat (3) @(posedge CLK_I);
        #1;
        check("reset_outputs", {miso, ADR_O, DAT_O, WE_O, STB_O, CYC_O, overrun, busErr}, 32'h0);
        #1 RST_I = 1'b1;
        repeat (4) @(posedge CLK_I);

        // Table-driven two-byte write frames against a zero-wait slave
        for (int v = 0; v < 4; v++) begin
            log_q.delete();
            stb_cycles = 0;
            tx_buf[0] = vecs[v].cmd;
            tx_buf[1] = vecs[v].d0;
            tx_buf[2] = vecs[v].d1;
            run_frame(3);
            check($sformatf("v%0d_nwrites", v), log_q.size(), 2);
            check($sformatf("v%0d_stb_cycles", v), stb_cycles, 2);
            check($sformatf("v%0d_flags", v), {overrun, busErr}, 2'b00);
            if (log_q.size() >= 2) begin
                check($sformatf("v%0d_we", v), {log_q[0].we, log_q[1].we}, 2'b11);
                check($sformatf("v%0d_adr0", v), log_q[0].adr, vecs[v].adr0);
                check($sformatf("v%0d_dat0", v), log_q[0].dat, vecs[v].d0);
                check($sformatf("v%0d_adr1", v), log_q[1].adr,
                      AUTOINC ? vecs[v].adr1_inc : vecs[v].adr1_fix);
                check($sformatf("v%0d_dat1", v), log_q[1].dat, vecs[v].d1);
            end
        end

        // Read frame with turnaround byte and prefetch
        log_q.delete();
        mem[8'h12] = 8'h5A;
        mem[8'h13] = 8'hC3;
        tx_buf[0] = 8'h12; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        run_frame(4);
        check("rd_miso_cmd", rx_buf[0], 8'h00);
        check("rd_miso_turn", rx_buf[1], 8'h00);
        check("rd_miso_data0", rx_buf[2], 8'h5A);
        check("rd_miso_data1", rx_buf[3], AUTOINC ? 8'hC3 : 8'h5A);
        check("rd_nreads", log_q.size(), 4);
        if (log_q.size() >= 2) begin
            check("rd_first", {log_q[0].we, log_q[0].adr}, {1'b0, 8'h12});
            check("rd_prefetch", {log_q[1].we, log_q[1].adr}, {1'b0, AUTOINC ? 8'h13 : 8'h12});
        end
        check("rd_flags", {overrun, busErr}, 2'b00);

        // Three retries then ACK: four strobes, no bus error
        mem[8'h20] = 8'h9C;
        rty_left = 3;
        stb_pulses = 0;
        cs_low();
        spi_byte(8'h20, r);
        repeat (60) @(posedge CLK_I);
        #2;
        check("rty3_pulses", stb_pulses, 4);
        check("rty3_buserr", busErr, 1'b0);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        check("rty3_data", r, 8'h9C);
        cs_high();
        check("rty3_overrun", overrun, 1'b0);

        // Four retries: access abandoned, busErr set, 0xFF returned
        rty_left = 4;
        stb_pulses = 0;
        cs_low();
        spi_byte(8'h21, r);
        repeat (60) @(posedge CLK_I);
        #2;
        check("rty4_pulses", stb_pulses, 4);
        check("rty4_buserr", busErr, 1'b1);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        check("rty4_data", r, 8'hFF);
        cs_high();
        check("rty4_flags_after", {overrun, busErr}, 2'b01);
        cs_low();
        check("rty4_buserr_clear", busErr, 1'b0);
        cs_high();

        // Slow slave during a write burst: second byte dropped, overrun sticky until next cs fall
        log_q.delete();
        ack_delay = 150;
        tx_buf[0] = 8'h85; tx_buf[1] = 8'h01; tx_buf[2] = 8'h02;
        run_frame(3);
        check("ovr_flag", overrun, 1'b1);
        budget = 400;
        while (STB_O && budget > 0) begin
            @(posedge CLK_I);
            budget--;
        end
        #2;
        check("ovr_bus_done", STB_O, 1'b0);
        ack_delay = 0;
        check("ovr_nwrites", log_q.size(), 1);
        if (log_q.size() >= 1) check("ovr_dat", log_q[0].dat, 8'h01);
        check("ovr_buserr", busErr, 1'b0);
        cs_low();
        check("ovr_clear", overrun, 1'b0);
        cs_high();

        // Asynchronous reset while a write strobe is outstanding
        ack_delay = 50;
        cs_low();
        spi_byte(8'h85, r);
        spi_byte(8'h44, r);
        check("rst_pre_stb", STB_O, 1'b1);
        #1 RST_I = 1'b0;
        #1;
        check("rst_async_outputs", {miso, ADR_O, DAT_O, WE_O, STB_O, CYC_O, overrun, busErr}, 32'h0);
        cs = 1'b1;
        repeat (4) @(posedge CLK_I);
        #2 RST_I = 1'b1;
        ack_delay = 0;
        repeat (4) @(posedge CLK_I);
        log_q.delete();
        tx_buf[0] = 8'hA3; tx_buf[1] = 8'h5E;
        run_frame(2);
        check("post_rst_nwrites", log_q.size(), 1);
        if (log_q.size() >= 1)
            check("post_rst_write", {log_q[0].we, log_q[0].adr, log_q[0].dat}, {1'b1, 8'h23, 8'h5E});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_wishbone_bridge.md
# spi_slave_wishbone_bridge

SPI peripheral (slave) endpoint that turns SPI frames from an external or on-chip SPI master into Wishbone master cycles on an 8-bit internal bus. It is the far end of the team's SPI master: mode 0, MSB first, 8-bit bytes, active-low chip select. It is used to expose a register bank to a host micro over SPI.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for sck, mosi and cs.
- MAX_RETRIES, 3: reissues allowed per access after RTY_I.
- WB_TIMEOUT, 255: CLK_I cycles to wait for ACK_I/RTY_I before abandoning the access.

Ports:
- CLK_I  in  1  system clock; all logic is on posedge.
- RST_I  in  1  reset, asynchronous, active-low.
- sck  in  1  SPI clock, asynchronous to CLK_I, idles low.
- cs  in  1  chip select, active-low.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master; driven 0 while cs is high.
- ADR_O  out  8  Wishbone address; bit 7 is always 0.
- DAT_O  out  8  Wishbone write data.
- DAT_I  in  8  Wishbone read data.
- WE_O, STB_O, CYC_O  out  1 each  Wishbone control.
- ACK_I, RTY_I  in  1 each  Wishbone termination.
- overrun  out  1  sticky flag: a byte was lost or read data was late.
- busErr  out  1  sticky flag: retries exhausted or timeout.

## Operation
- sck, cs and mosi pass through SYNC_STAGES flops. Edges are detected from the last two synchronized samples.
- mosi is sampled on the sck rising edge. miso changes on the sck falling edge. The first miso bit of a frame is valid on the cs falling edge.
- Byte 0 is the command: bit 7 = 1 for write, 0 for read; bits 6:0 are the address.
- Frame FSM states: IDLE, COMMAND, WRITE_DATA, READ_TURN, READ_DATA.
  - IDLE→COMMAND on the cs falling edge. The bit counter clears to 0.
  - COMMAND→WRITE_DATA or READ_TURN after the 8th rising edge.
  - In WRITE_DATA, each completed byte issues a Wishbone write to the current address. The address then advances (see Configuration).
  - READ_TURN issues a Wishbone read when it is entered. miso shifts 0x00 during this byte. After 8 edges the read data loads into the shift register and the state goes to READ_DATA.
  - In READ_DATA, a prefetch read of the next address is issued when each byte is loaded. The prefetched data loads at each byte boundary.
  - Any state→IDLE on the cs rising edge. A partial byte is discarded. An in-flight Wishbone cycle completes normally.
- Bus FSM states: BUS_IDLE, BUS_ACTIVE, BUS_GAP.
  - BUS_ACTIVE asserts CYC_O, STB_O and WE_O together until ACK_I, RTY_I or timeout.
  - ACK_I: read data is latched and the FSM returns to BUS_IDLE.
  - RTY_I: BUS_GAP for 1 cycle, then reissue. After MAX_RETRIES reissues, set busErr and abandon the access. An abandoned read returns 0xFF.
  - Timeout counter exceeds WB_TIMEOUT: abandon the access and set busErr.
- overrun is set in two cases:
  - A write byte completes while the bus FSM is not in BUS_IDLE. That byte is dropped.
  - Read data is not ready at a load point. 0xFF is shifted out instead.
- overrun and busErr clear on the next cs falling edge.
- Address arithmetic is 7 bits and wraps from 0x7F to 0x00.

## Timing
- Reset values: miso=0, ADR_O=0, DAT_O=0, WE_O=STB_O=CYC_O=0, overrun=0, busErr=0. Both FSMs are idle and the counters are 0.
- Requirement: sck high and low phases are each ≥ SYNC_STAGES+2 CLK_I cycles.
- Edge-to-action latency is SYNC_STAGES+1 CLK_I cycles.
- STB_O rises 1 cycle after the byte-complete detection.
- A zero-wait slave (ACK_I the same cycle STB_O is seen) gives a 1-cycle bus cycle. STB_O drops the cycle after ACK_I.
- Read data is guaranteed on time if the bus completes within 8 sck periods.
- cs rising at the same sample as a final sck edge: the edge is processed first, then the frame closes.
- Reset asserted mid-frame or mid-cycle: STB_O and CYC_O drop immediately (asynchronous), all state clears, and no retry is pending.

## Configuration
- SPI_SLAVE_AUTOINC_EN defined: the address increments after every data byte, giving bursts over consecutive registers.
- Not defined: the address stays fixed for the whole frame. Bursts repeatedly write or read the same register (FIFO port).

## Structure
- Package spi_slave_pkg holds:
  - the frame and bus state enums;
  - the command-field constants CMD_WRITE_BIT=7 and ADDR_BITS=7;
  - the abandoned-read value 0xFF.
- One sub-module, spiEdgeSync, contains the synchronizers plus rise/fall detectors for sck and the cs edges. It is instantiated once.

## Test plan
- Write: cs low, send 0x85 then 0x3C → one Wishbone write with ADR_O=0x05, DAT_O=0x3C, WE_O=1.
- Read: slave holds 0x5A at 0x12. Send 0x12, 0x00, 0x00 → miso returns 0x00, then 0x5A. A prefetch read of 0x13 is seen with AUTOINC_EN.
- Burst wrap: write command to 0x7F, then data 0x11, 0x22 → writes to 0x7F, then 0x00 (macro on). Without the macro, both writes go to 0x7F.
- Retry: slave answers RTY_I 3 times, then ACK_I → 4 STB_O pulses, busErr=0. With RTY_I 4 times → busErr=1 and the read returns 0xFF.
- Overrun: slave withholds ACK_I longer than 8 sck periods during a write burst → the second byte is dropped and overrun=1, cleared by the next cs fall.
- Asynchronous reset mid-cycle with STB_O high → all outputs at reset values in the same cycle; a subsequent frame works normally.
